rnn_step_scheduler: RTL and testbench

RNN_STEP_SCHEDULER -- requirements
Module: rnn_step_scheduler

---
 rtl/rnn_step_scheduler.sv | 122 ++++++++++++
 tb/tb_rnn_step_scheduler.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rnn_step_scheduler.sv
// Time-multiplexed RNN step scheduler: walks every neuron slot through one shared
// update datapath, stores the returned membrane state and collects the spike vector.
module rnn_step_scheduler #(
  parameter int N_SLOTS = 4,
  parameter int W = 8,
  parameter int TIMEOUT = 15,
  localparam int SW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1,
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 step_start,
  input  logic                 clear_state,
  input  logic [N_SLOTS*W-1:0] current_in,
  output logic                 busy,
  output logic                 step_done,
  output logic [N_SLOTS-1:0]   spikes,
  output logic                 err_timeout,
  output logic                 dp_valid,
  output logic [SW-1:0]        dp_slot,
  output logic [W-1:0]         dp_current,
  output logic [W-1:0]         dp_state,
  input  logic                 dp_ready,
  input  logic                 dp_result_valid,
  input  logic [W-1:0]         dp_result_state,
  input  logic                 dp_result_spike
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [SW-1:0] LAST_SLOT = SW'(N_SLOTS - 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

  state_t               state, state_next;
  logic [SW-1:0]        slot;
  logic [TW-1:0]        timer;
  logic [N_SLOTS*W-1:0] cur_latched;
  logic [W-1:0]         mem [N_SLOTS];
  logic [N_SLOTS-1:0]   pending;

  logic start_ok, clear_ok, issue_fire, result_take, timer_expire, wait_exit;

  assign dp_slot    = slot;
  assign dp_current = cur_latched[slot*W +: W];
  assign dp_state   = mem[slot];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    busy         = (state != IDLE);
    step_done    = 1'b0;
    dp_valid     = 1'b0;
    start_ok     = 1'b0;
    clear_ok     = 1'b0;
    issue_fire   = 1'b0;
    result_take  = 1'b0;
    timer_expire = 1'b0;
    wait_exit    = 1'b0;
    case (state)
      IDLE: begin
        clear_ok = clear_state;
        start_ok = step_start && !clear_state;
        if (start_ok) state_next = ISSUE;
      end
      ISSUE: begin
        dp_valid   = 1'b1;
        issue_fire = dp_ready;
        if (dp_ready) state_next = WAIT;
      end
      WAIT: begin
        // A result arriving on the expiry cycle still counts as a result.
        result_take  = dp_result_valid;
        timer_expire = !dp_result_valid && (timer == TIMER_MAX);
        wait_exit    = result_take || timer_expire;
        if (wait_exit) state_next = (slot == LAST_SLOT) ? DONE : ISSUE;
      end
      DONE: begin
        step_done  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot        <= '0;
      timer       <= '0;
      cur_latched <= '0;
      pending     <= '0;
      spikes      <= '0;
      err_timeout <= 1'b0;
      for (int i = 0; i < N_SLOTS; i++) mem[i] <= '0;
    end else begin
      if (clear_ok) begin
        for (int i = 0; i < N_SLOTS; i++) mem[i] <= '0;
      end
      if (start_ok) begin
        cur_latched <= current_in;
        slot        <= '0;
        pending     <= '0;
      end
      if (issue_fire) timer <= '0;
      else if (state == WAIT && !wait_exit) timer <= timer + 1'b1;
      if (result_take) begin
        mem[slot]     <= dp_result_state;
        pending[slot] <= dp_result_spike;
      end
      if (timer_expire) begin
        err_timeout   <= 1'b1;
        pending[slot] <= 1'b0;
      end
      if (wait_exit && slot != LAST_SLOT) slot <= slot + 1'b1;
      if (step_done) spikes <= pending;
    end
  end

endmodule

// File: tb/tb_rnn_step_scheduler.sv
// Scoreboard bench for rnn_step_scheduler: directed steps push expected datapath
// requests and step results; a monitor process pops and compares them.
module tb_rnn_step_scheduler;
  localparam int N = 4;
  localparam int W = 8;

  typedef struct packed {
    logic [1:0]   slot;
    logic [W-1:0] cur;
    logic [W-1:0] st;
  } req_t;

  typedef struct packed {
    logic [N-1:0] spk;
    int           cyc;
  } done_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         step_start = 1'b0;
  logic         clear_state = 1'b0;
  logic [N*W-1:0] current_in = '0;
  logic         busy, step_done, err_timeout, dp_valid;
  logic [N-1:0] spikes;
  logic [1:0]   dp_slot;
  logic [W-1:0] dp_current, dp_state;
  logic         dp_ready = 1'b1;
  logic         dp_result_valid = 1'b0;
  logic [W-1:0] dp_result_state = '0;
  logic         dp_result_spike = 1'b0;

  rnn_step_scheduler #(.N_SLOTS(N), .W(W), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .step_start(step_start), .clear_state(clear_state),
    .current_in(current_in), .busy(busy), .step_done(step_done), .spikes(spikes),
    .err_timeout(err_timeout), .dp_valid(dp_valid), .dp_slot(dp_slot),
    .dp_current(dp_current), .dp_state(dp_state), .dp_ready(dp_ready),
    .dp_result_valid(dp_result_valid), .dp_result_state(dp_result_state),
    .dp_result_spike(dp_result_spike)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int last_start = 0;
  req_t  req_q[$];
  done_t done_q[$];

  int       bp_slot = 0;
  int       bp_len = 0;
  logic     drop_en = 1'b0;
  int       drop_slot = 0;
  logic     stray_en = 1'b0;
  int       stray_slot = 0;

  logic     hs_seen = 1'b0;
  logic [W:0] hs_sum = '0;
  logic [1:0] hs_slot = '0;
  int       stall_cnt = 0;
  logic     stray_used = 1'b0;

  always @(negedge clk) begin
    hs_seen = dp_valid && dp_ready;
    hs_sum  = {1'b0, dp_state} + {1'b0, dp_current};
    hs_slot = dp_slot;
  end

  // Echo datapath: result one cycle after the handshake, plus optional stalls,
  // dropped results and one stray result while a request is still in ISSUE.
  always @(posedge clk) begin
    #1;
    if (!busy) begin
      stall_cnt  = 0;
      stray_used = 1'b0;
    end
    if (dp_valid && int'(dp_slot) == bp_slot && stall_cnt < bp_len) begin
      dp_ready = 1'b0;
      stall_cnt++;
    end else begin
      dp_ready = 1'b1;
    end
    dp_result_valid = 1'b0;
    dp_result_state = '0;
    dp_result_spike = 1'b0;
    if (hs_seen && !(drop_en && int'(hs_slot) == drop_slot)) begin
      dp_result_valid = 1'b1;
      dp_result_state = hs_sum[W-1:0];
      dp_result_spike = (hs_sum >= 9'd100);
    end else if (stray_en && !stray_used && dp_valid && int'(dp_slot) == stray_slot) begin
      dp_result_valid = 1'b1;
      dp_result_state = 8'd77;
      dp_result_spike = 1'b1;
      stray_used      = 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [N*W-1:0] cur, input logic [N*W-1:0] st,
                               input logic [N-1:0] exp_spk, input int lat, input int n_req);
    req_t  r;
    done_t d;
    for (int i = 0; i < n_req; i++) begin
      r.slot = 2'(i);
      r.cur  = cur[i*W +: W];
      r.st   = st[i*W +: W];
      req_q.push_back(r);
    end
    @(posedge clk); #1;
    last_start = cyc;
    if (lat > 0) begin
      d.spk = exp_spk;
      d.cyc = cyc + lat;
      done_q.push_back(d);
    end
    current_in = cur;
    step_start = 1'b1;
    @(posedge clk); #1;
    step_start = 1'b0;
  endtask

  task automatic waitCycle(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic waitIdle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 200);
    checkOutput("step_reaches_idle", busy, 0);
  endtask

  initial begin
    fork
      begin : monitor
        req_t  r;
        done_t d;
        logic       stalled = 1'b0;
        logic [1:0] hold_slot = '0;
        logic [W-1:0] hold_cur = '0, hold_st = '0;
        forever begin
          @(negedge clk);
          if (dp_valid && dp_ready) begin
            if (req_q.size() == 0) begin
              checks++;
              failures++;
              $display("[TB] FAIL unexpected_request slot=%0d", dp_slot);
            end else begin
              r = req_q.pop_front();
              checkOutput("req_slot", 32'(dp_slot), 32'(r.slot));
              checkOutput("req_current", 32'(dp_current), 32'(r.cur));
              checkOutput("req_state", 32'(dp_state), 32'(r.st));
            end
          end
          if (dp_valid && !dp_ready) begin
            if (stalled) begin
              checkOutput("stall_slot", 32'(dp_slot), 32'(hold_slot));
              checkOutput("stall_current", 32'(dp_current), 32'(hold_cur));
              checkOutput("stall_state", 32'(dp_state), 32'(hold_st));
            end
            stalled   = 1'b1;
            hold_slot = dp_slot;
            hold_cur  = dp_current;
            hold_st   = dp_state;
          end else begin
            stalled = 1'b0;
          end
          if (step_done) begin
            if (done_q.size() == 0) begin
              checks++;
              failures++;
              $display("[TB] FAIL unexpected_step_done cycle=%0d", cyc);
            end else begin
              d = done_q.pop_front();
              checkOutput("done_cycle", cyc - last_start, d.cyc - last_start);
              @(negedge clk);
              checkOutput("spikes", 32'(spikes), 32'(d.spk));
              checkOutput("done_one_cycle", 32'(step_done), 0);
            end
          end
        end
      end
      begin : main_seq
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_step_done", step_done, 0);
        checkOutput("rst_spikes", 32'(spikes), 0);
        checkOutput("rst_err", err_timeout, 0);
        checkOutput("rst_dp_valid", dp_valid, 0);

        // Nominal step
        applyStimulus({8'd0, 8'd100, 8'd50, 8'd10}, '0, 4'b0100, 9, 4);
        waitIdle();
        checkOutput("err_after_nominal", err_timeout, 0);

        // Back-pressure on slot 1
        bp_slot = 1; bp_len = 3;
        applyStimulus({8'd4, 8'd3, 8'd2, 8'd1}, {8'd0, 8'd100, 8'd50, 8'd10}, 4'b0100, 12, 4);
        waitIdle();
        bp_len = 0;

        // Slot 2 never answers
        drop_en = 1'b1; drop_slot = 2;
        applyStimulus({8'd0, 8'd5, 8'd0, 8'd100}, {8'd4, 8'd103, 8'd52, 8'd11}, 4'b0001, 23, 4);
        waitIdle();
        drop_en = 1'b0;
        checkOutput("err_after_timeout", err_timeout, 1);

        // Stray result in ISSUE, step_start while busy and during DONE
        stray_en = 1'b1; stray_slot = 1;
        applyStimulus('0, {8'd4, 8'd103, 8'd52, 8'd111}, 4'b0101, 9, 4);
        waitCycle(last_start + 3);
        step_start = 1'b1;
        @(posedge clk); #1;
        step_start = 1'b0;
        waitCycle(last_start + 9);
        step_start = 1'b1;
        @(posedge clk); #1;
        step_start = 1'b0;
        @(negedge clk);
        checkOutput("start_in_done_ignored", busy, 0);
        stray_en = 1'b0;
        checkOutput("err_sticky", err_timeout, 1);

        // clear_state beats step_start
        @(posedge clk); #1;
        step_start = 1'b1; clear_state = 1'b1;
        @(posedge clk); #1;
        step_start = 1'b0; clear_state = 1'b0;
        @(negedge clk);
        checkOutput("collision_busy", busy, 0);
        applyStimulus({8'd4, 8'd3, 8'd2, 8'd1}, '0, 4'b0000, 9, 4);
        waitIdle();

        // Reset during slot 2 WAIT
        drop_en = 1'b1; drop_slot = 2;
        applyStimulus({8'd10, 8'd10, 8'd10, 8'd10}, {8'd4, 8'd3, 8'd2, 8'd1}, '0, 0, 3);
        waitCycle(last_start + 8);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_dp_valid", dp_valid, 0);
        checkOutput("midrst_spikes", 32'(spikes), 0);
        checkOutput("midrst_err", err_timeout, 0);
        checkOutput("midrst_step_done", step_done, 0);
        drop_en = 1'b0;

        applyStimulus({8'd0, 8'd100, 8'd50, 8'd10}, '0, 4'b0100, 9, 4);
        waitIdle();
        repeat (3) @(negedge clk);
        checkOutput("req_queue_drained", req_q.size(), 0);
        checkOutput("done_queue_drained", done_q.size(), 0);
        checkOutput("err_final", err_timeout, 0);
      end
      begin : watchdog
        repeat (20000) @(posedge clk);
        checks++;
        failures++;
        $display("[TB] FAIL watchdog_expired cycle=%0d", cyc);
      end
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
